// File: rtl/lfsr_sequence_controller_if.sv
// Command bus between the top-level input decode (master) and the
// LFSR sequence controller (slave). A command is taken on any clock
// where cmd_valid and cmd_ready are both high.
interface lfsr_sequence_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cmd_valid;
  logic [2:0]           cmd_op;
  logic [CNT_WIDTH-1:0] cmd_arg;
  logic                 cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/lfsr_sequence_controller.sv
// Command-driven sequencer for a single Fibonacci LFSR. It owns the LFSR
// configuration and issues every step/reseed strobe, providing free-run,
// hold, single-step, counted bursts and automatic period measurement.
// Everything runs on the system clock; stepping is an enable, not a gated
// clock. All outputs are flops except lfsr_step while measuring, which must
// react in the same cycle the LFSR value comes back round to the seed.
module lfsr_sequence_controller #(
  parameter int         CNT_WIDTH = 16,
  parameter logic [7:0] SEED      = 8'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  lfsr_sequence_controller_if.slave  cmd,
  input  logic [7:0]                 lfsr_value,
  input  logic                       lfsr_valid,
  output logic [2:0]                 lfsr_length,
  output logic                       lfsr_n_taps,
  output logic                       lfsr_step,
  output logic                       lfsr_load,
  output logic [2:0]                 ctl_state,
  output logic [CNT_WIDTH-1:0]       period,
  output logic                       period_valid,
  output logic                       err_invalid,
  output logic                       err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_BURST   = 3'd3,
    ST_LOAD    = 3'd4,
    ST_MEASURE = 3'd5
  } state_e;

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HOLD    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_BURST   = 3'd4;
  localparam logic [2:0] OP_MEASURE = 3'd5;
  localparam logic [2:0] OP_CONFIG  = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           length_q, length_d;
  logic                 n_taps_q, n_taps_d;
  logic                 step_q, step_d;
  logic                 load_q, load_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 period_valid_q, period_valid_d;
  logic                 err_invalid_q, err_invalid_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 ready_q, ready_d;

  logic [7:0]           mask_s;
  logic                 match_s;
  logic                 meas_step_s;
  logic                 accept_s;

  // Seed match on the active low bits, and the measuring step enable.
  always_comb begin
    mask_s      = (8'd1 << length_q) - 8'd1;
    match_s     = (((lfsr_value ^ SEED) & mask_s) == 8'd0);
    // Stop stepping the moment the value is back at the seed (k >= 1),
    // so the LFSR is left holding the seed state.
    meas_step_s = (state_q == ST_MEASURE) && !((cnt_q != CNT_ZERO) && match_s);
    accept_s    = cmd.cmd_valid && ready_q;
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    length_d       = length_q;
    n_taps_d       = n_taps_q;
    step_d         = 1'b0;
    load_d         = 1'b0;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    err_invalid_d  = err_invalid_q;
    err_timeout_d  = err_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
              step_d  = 1'b1;
            end
            OP_STEP: begin
              state_d = ST_STEP;
              step_d  = 1'b1;
            end
            OP_BURST: begin
              // A zero-length burst is a no-op.
              if (cmd.cmd_arg != CNT_ZERO) begin
                state_d = ST_BURST;
                cnt_d   = cmd.cmd_arg;
                step_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
            OP_MEASURE: begin
              state_d        = ST_LOAD;
              load_d         = 1'b1;
              period_valid_d = 1'b0;
            end
            OP_CONFIG: begin
              // New configuration is reseeded right away; old results no
              // longer describe this LFSR.
              length_d       = cmd.cmd_arg[2:0];
              n_taps_d       = cmd.cmd_arg[3];
              load_d         = 1'b1;
              period_valid_d = 1'b0;
              err_invalid_d  = 1'b0;
              err_timeout_d  = 1'b0;
            end
            default: begin
              // NOP, HOLD and the reserved opcode do nothing in IDLE.
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (!lfsr_valid) begin
          err_invalid_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (accept_s && (cmd.cmd_op == OP_HOLD)) begin
          state_d = ST_IDLE;
        end else begin
          // Every other command is dropped while free-running.
          step_d = 1'b1;
        end
      end

      ST_STEP: begin
        if (!lfsr_valid) begin
          err_invalid_d = 1'b1;
        end else begin
          err_invalid_d = err_invalid_q;
        end
        state_d = ST_IDLE;
      end

      ST_BURST: begin
        if (!lfsr_valid) begin
          err_invalid_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - CNT_ONE;
          step_d = 1'b1;
        end
      end

      ST_LOAD: begin
        state_d = ST_MEASURE;
        cnt_d   = CNT_ZERO;
      end

      ST_MEASURE: begin
        if ((cnt_q != CNT_ZERO) && match_s) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (!lfsr_valid) begin
          err_invalid_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          // Saturate instead of wrapping: report all ones and flag it.
          period_d       = CNT_MAX;
          period_valid_d = 1'b1;
          err_timeout_d  = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= CNT_ZERO;
      length_q       <= 3'd7;
      n_taps_q       <= 1'b0;
      step_q         <= 1'b0;
      load_q         <= 1'b0;
      period_q       <= CNT_ZERO;
      period_valid_q <= 1'b0;
      err_invalid_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
      ready_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      length_q       <= length_d;
      n_taps_q       <= n_taps_d;
      step_q         <= step_d;
      load_q         <= load_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      err_invalid_q  <= err_invalid_d;
      err_timeout_q  <= err_timeout_d;
      ready_q        <= ready_d;
    end
  end

  assign cmd.cmd_ready  = ready_q;
  assign lfsr_length    = length_q;
  assign lfsr_n_taps    = n_taps_q;
  assign lfsr_step      = step_q | meas_step_s;
  assign lfsr_load      = load_q;
  assign ctl_state      = state_q;
  assign period         = period_q;
  assign period_valid   = period_valid_q;
  assign err_invalid    = err_invalid_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_lfsr_sequence_controller.sv
// Bench for lfsr_sequence_controller: a behavioural LFSR is attached to the
// controller, and directed plus randomized command sequences are checked
// against expectations derived from LFSR theory and command semantics.
module tb_lfsr_sequence_controller;

  localparam int         CW   = 16;
  localparam logic [7:0] SEED = 8'd1;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HOLD    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_BURST   = 3'd4;
  localparam logic [2:0] OP_MEASURE = 3'd5;
  localparam logic [2:0] OP_CONFIG  = 3'd6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    lfsr_value;
  logic          lfsr_valid = 1'b1;
  logic [2:0]    lfsr_length;
  logic          lfsr_n_taps;
  logic          lfsr_step;
  logic          lfsr_load;
  logic [2:0]    ctl_state;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          err_invalid;
  logic          err_timeout;

  int checks   = 0;
  int failures = 0;

  lfsr_sequence_controller_if #(.CNT_WIDTH(CW)) cif ();

  lfsr_sequence_controller #(.CNT_WIDTH(CW), .SEED(SEED)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cif.slave),
    .lfsr_value   (lfsr_value),
    .lfsr_valid   (lfsr_valid),
    .lfsr_length  (lfsr_length),
    .lfsr_n_taps  (lfsr_n_taps),
    .lfsr_step    (lfsr_step),
    .lfsr_load    (lfsr_load),
    .ctl_state    (ctl_state),
    .period       (period),
    .period_valid (period_valid),
    .err_invalid  (err_invalid),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural LFSR: one maximal-length 2-tap polynomial per length,
  // state kept to the low 'len' bits.
  function automatic logic [7:0] len_mask(input logic [2:0] len);
    logic [7:0] one;
    one = 8'd1;
    return (one << len) - 8'd1;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [2:0] len);
    logic fb;
    case (len)
      3'd1:    fb = s[0];
      3'd2:    fb = s[1] ^ s[0];
      3'd3:    fb = s[2] ^ s[1];
      3'd4:    fb = s[3] ^ s[2];
      3'd5:    fb = s[4] ^ s[2];
      3'd6:    fb = s[5] ^ s[4];
      3'd7:    fb = s[6] ^ s[5];
      default: fb = 1'b0;
    endcase
    return {s[6:0], fb} & len_mask(len);
  endfunction

  // Expected period of a maximal LFSR of the given length.
  function automatic int exp_period(input int len);
    return (len <= 1) ? 1 : ((1 << len) - 1);
  endfunction

  logic [7:0] lfsr_q = 8'd1;
  logic       stuck  = 1'b0;

  // The LFSR itself: reseed on load, advance on step.
  always @(posedge clk) begin
    if (lfsr_load)      lfsr_q <= SEED & len_mask(lfsr_length);
    else if (lfsr_step) lfsr_q <= lfsr_next(lfsr_q, lfsr_length);
  end

  assign lfsr_value = stuck ? ~SEED : lfsr_q;

  int step_cnt = 0;
  int load_cnt = 0;
  int both_cnt = 0;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (lfsr_step)              step_cnt <= step_cnt + 1;
    if (lfsr_load)              load_cnt <= load_cnt + 1;
    if (lfsr_step && lfsr_load) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [CW-1:0] arg);
    int n;
    n = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    while (!cif.cmd_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("send_ready_wait", 32'(n < 1000), 32'd1);
    tick();
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_NOP;
    cif.cmd_arg   = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (ctl_state != 3'd0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_wait", 32'(ctl_state), 32'd0);
  endtask

  function automatic logic [CW-1:0] cfg_arg(input int len, input int nt);
    return CW'(len & 7) | (CW'(nt & 1) << 3);
  endfunction

  task automatic config_measure(input int len, input int nt);
    send(OP_CONFIG, cfg_arg(len, nt));
    chk("cfg_clears_pv", 32'(period_valid), 32'd0);
    chk("cfg_length", 32'(lfsr_length), 32'(len));
    chk("cfg_ntaps", 32'(lfsr_n_taps), 32'(nt));
    send(OP_MEASURE, '0);
    wait_idle(400);
    chk("meas_period", 32'(period), 32'(exp_period(len)));
    chk("meas_pv", 32'(period_valid), 32'd1);
    chk("meas_err", 32'({err_invalid, err_timeout}), 32'd0);
    chk("meas_left_at_seed", 32'(lfsr_q), 32'(SEED & len_mask(3'(len))));
  endtask

  initial begin
    int base;
    int n;
    int r1;
    int r2;
    int len;
    logic rdy_seen;

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_NOP;
    cif.cmd_arg   = '0;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(ctl_state), 32'd0);
    chk("rst_length", 32'(lfsr_length), 32'd7);
    chk("rst_ntaps", 32'(lfsr_n_taps), 32'd0);
    chk("rst_strobes", 32'({lfsr_step, lfsr_load}), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_flags", 32'({period_valid, err_invalid, err_timeout}), 32'd0);
    chk("rst_ready", 32'(cif.cmd_ready), 32'd1);
    rst = 1'b0;
    tick();

    // CONFIG length 3 / 2 taps, then MEASURE: two reseeds, period 7.
    base = load_cnt;
    config_measure(3, 0);
    chk("two_loads", 32'(load_cnt - base), 32'd2);

    // Long and medium measurements.
    config_measure(7, 0);
    config_measure(4, 0);

    // Randomized configurations.
    for (int i = 0; i < 4; i++) begin
      len = int'($urandom_range(2, 7));
      config_measure(len, int'($urandom_range(0, 1)));
    end

    // BURST of 5: exactly five steps, never ready.
    base = step_cnt;
    send(OP_BURST, CW'(5));
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rdy_seen = rdy_seen | cif.cmd_ready;
      tick();
    end
    chk("burst5_idle", 32'(ctl_state), 32'd0);
    tick();
    tick();
    chk("burst5_steps", 32'(step_cnt - base), 32'd5);
    chk("burst5_not_ready", 32'(rdy_seen), 32'd0);

    // Randomized bursts.
    for (int j = 0; j < 3; j++) begin
      n = int'($urandom_range(1, 30));
      base = step_cnt;
      send(OP_BURST, CW'(n));
      wait_idle(100);
      tick();
      chk("burst_rand_steps", 32'(step_cnt - base), 32'(n));
    end

    // BURST 0 does nothing.
    base = step_cnt;
    send(OP_BURST, CW'(0));
    chk("burst0_state", 32'(ctl_state), 32'd0);
    tick();
    tick();
    chk("burst0_steps", 32'(step_cnt - base), 32'd0);

    // STEP is exactly one advance.
    base = step_cnt;
    send(OP_STEP, '0);
    chk("step_state", 32'(ctl_state), 32'd2);
    tick();
    chk("step_back_idle", 32'(ctl_state), 32'd0);
    tick();
    chk("step_count", 32'(step_cnt - base), 32'd1);

    // RUN 10 cycles then HOLD: 11 steps including the accept cycle.
    base = step_cnt;
    send(OP_RUN, '0);
    for (int i = 0; i < 10; i++) tick();
    send(OP_HOLD, '0);
    chk("hold_idle", 32'(ctl_state), 32'd0);
    tick();
    tick();
    chk("run_hold_steps", 32'(step_cnt - base), 32'd11);

    // RUN with a BURST in the middle: the BURST is dropped.
    r1 = int'($urandom_range(0, 8));
    r2 = int'($urandom_range(0, 8));
    base = step_cnt;
    send(OP_RUN, '0);
    for (int i = 0; i < r1; i++) tick();
    send(OP_BURST, CW'(20));
    chk("run_ignores_burst", 32'(ctl_state), 32'd1);
    for (int i = 0; i < r2; i++) tick();
    send(OP_HOLD, '0);
    for (int i = 0; i < 25; i++) tick();
    chk("run_burst_steps", 32'(step_cnt - base), 32'(r1 + r2 + 2));
    chk("run_burst_idle", 32'(ctl_state), 32'd0);

    // Invalid LFSR while running: sticky error, abort to IDLE.
    send(OP_CONFIG, cfg_arg(1, 0));
    lfsr_valid = 1'b0;
    send(OP_RUN, '0);
    chk("inv_in_run", 32'(ctl_state), 32'd1);
    tick();
    chk("inv_err", 32'(err_invalid), 32'd1);
    chk("inv_idle", 32'(ctl_state), 32'd0);
    lfsr_valid = 1'b1;
    tick();
    chk("inv_sticky", 32'(err_invalid), 32'd1);
    send(OP_CONFIG, cfg_arg(2, 0));
    chk("cfg_clears_inv", 32'(err_invalid), 32'd0);

    // Measurement that never matches saturates and flags a timeout.
    send(OP_CONFIG, cfg_arg(7, 0));
    stuck = 1'b1;
    send(OP_MEASURE, '0);
    wait_idle(70000);
    stuck = 1'b0;
    chk("tmo_period", 32'(period), 32'hFFFF);
    chk("tmo_pv", 32'(period_valid), 32'd1);
    chk("tmo_err", 32'({err_timeout, err_invalid}), 32'b10);
    config_measure(5, 1);
    chk("cfg_clears_tmo", 32'(err_timeout), 32'd0);

    // Reset in the middle of a measurement (k = 40).
    send(OP_CONFIG, cfg_arg(6, 1));
    send(OP_MEASURE, '0);
    tick();
    for (int i = 0; i < 40; i++) tick();
    chk("mid_meas_state", 32'(ctl_state), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_state", 32'(ctl_state), 32'd0);
    chk("mrst_length", 32'(lfsr_length), 32'd7);
    chk("mrst_ntaps", 32'(lfsr_n_taps), 32'd0);
    chk("mrst_strobes", 32'({lfsr_step, lfsr_load}), 32'd0);
    chk("mrst_period", 32'(period), 32'd0);
    chk("mrst_flags", 32'({period_valid, err_invalid, err_timeout}), 32'd0);
    chk("mrst_ready", 32'(cif.cmd_ready), 32'd1);
    tick();
    tick();
    chk("mrst_stays_idle", 32'(ctl_state), 32'd0);

    // Load and step never coincide across the whole run.
    chk("no_load_step_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
